// File: rtl/proc_alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational proc ALU between two
// val/rdy requesters. The ALU result and flags land in a single response
// slot that is returned to the requester that issued the operation.
module proc_alu_share_arbiter #(
    parameter int p_nbits = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic               req0_val_i,
    output logic               req0_rdy_o,
    input  logic [3:0]         req0_fn_i,
    input  logic [p_nbits-1:0] req0_in0_i,
    input  logic [p_nbits-1:0] req0_in1_i,

    input  logic               req1_val_i,
    output logic               req1_rdy_o,
    input  logic [3:0]         req1_fn_i,
    input  logic [p_nbits-1:0] req1_in0_i,
    input  logic [p_nbits-1:0] req1_in1_i,

    output logic               resp0_val_o,
    input  logic               resp0_rdy_i,
    output logic               resp1_val_o,
    input  logic               resp1_rdy_i,
    output logic [p_nbits-1:0] resp_out_o,
    output logic               resp_eq_o,
    output logic               resp_lt_o,
    output logic               resp_ltu_o,

    output logic [3:0]         alu_fn_o,
    output logic [p_nbits-1:0] alu_in0_o,
    output logic [p_nbits-1:0] alu_in1_o,
    input  logic [p_nbits-1:0] alu_out_i,
    input  logic               alu_eq_i,
    input  logic               alu_lt_i,
    input  logic               alu_ltu_i
);

    logic               rrLast_q,  rrLast_d;
    logic               sVal_q,    sVal_d;
    logic               sOwner_q,  sOwner_d;
    logic [p_nbits-1:0] sOut_q,    sOut_d;
    logic               sEq_q,     sEq_d;
    logic               sLt_q,     sLt_d;
    logic               sLtu_q,    sLtu_d;

    logic grantValid;
    logic grantId;
    logic respFire;
    logic sFree;
    logic reqFire;

    // Pick a requester: a lone requester wins outright, a tie goes to the
    // one that was not granted last so neither side can be starved.
    always_comb begin
        grantValid = req0_val_i | req1_val_i;
        grantId    = 1'b0;
        if (req0_val_i && req1_val_i) begin
            grantId = ~rrLast_q;
        end else if (req1_val_i) begin
            grantId = 1'b1;
        end
    end

    // The slot can take a new result when empty, or when its current owner
    // drains it this very cycle, which keeps throughput at one op per cycle.
    always_comb begin
        respFire   = sVal_q & (sOwner_q ? resp1_rdy_i : resp0_rdy_i);
        sFree      = ~sVal_q | respFire;
        reqFire    = sFree & grantValid;
        req0_rdy_o = reqFire & ~grantId;
        req1_rdy_o = reqFire &  grantId;
    end

    // Steer the granted requester's operands to the ALU; park at zero
    // when nobody is asking.
    always_comb begin
        alu_fn_o  = '0;
        alu_in0_o = '0;
        alu_in1_o = '0;
        if (grantValid) begin
            if (grantId) begin
                alu_fn_o  = req1_fn_i;
                alu_in0_o = req1_in0_i;
                alu_in1_o = req1_in1_i;
            end else begin
                alu_fn_o  = req0_fn_i;
                alu_in0_o = req0_in0_i;
                alu_in1_o = req0_in1_i;
            end
        end
    end

    // Next slot state: capture on accept, clear on drain, otherwise hold
    // everything so a stalled response stays stable for its owner.
    always_comb begin
        rrLast_d = rrLast_q;
        sVal_d   = sVal_q;
        sOwner_d = sOwner_q;
        sOut_d   = sOut_q;
        sEq_d    = sEq_q;
        sLt_d    = sLt_q;
        sLtu_d   = sLtu_q;
        if (reqFire) begin
            sVal_d   = 1'b1;
            sOwner_d = grantId;
            sOut_d   = alu_out_i;
            sEq_d    = alu_eq_i;
            sLt_d    = alu_lt_i;
            sLtu_d   = alu_ltu_i;
            rrLast_d = grantId;
        end else if (respFire) begin
            sVal_d   = 1'b0;
        end
    end

    // State register; rrLast resets to 1 so requester 0 wins the first tie,
    // and any in-flight result is dropped on reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rrLast_q <= 1'b1;
            sVal_q   <= 1'b0;
            sOwner_q <= 1'b0;
            sOut_q   <= '0;
            sEq_q    <= 1'b0;
            sLt_q    <= 1'b0;
            sLtu_q   <= 1'b0;
        end else begin
            rrLast_q <= rrLast_d;
            sVal_q   <= sVal_d;
            sOwner_q <= sOwner_d;
            sOut_q   <= sOut_d;
            sEq_q    <= sEq_d;
            sLt_q    <= sLt_d;
            sLtu_q   <= sLtu_d;
        end
    end

    // Response outputs come straight from the slot registers.
    always_comb begin
        resp0_val_o = sVal_q & ~sOwner_q;
        resp1_val_o = sVal_q &  sOwner_q;
        resp_out_o  = sOut_q;
        resp_eq_o   = sEq_q;
        resp_lt_o   = sLt_q;
        resp_ltu_o  = sLtu_q;
    end

endmodule

// File: tb/tb_proc_alu_share_arbiter.sv
// Scoreboard bench for the shared-ALU arbiter: a behavioural ALU sits on
// the alu_* port, accepted requests push expected responses into a queue,
// and an independent monitor pops and compares them as the DUT answers.
module tb_proc_alu_share_arbiter;

    typedef struct {
        logic        id;
        logic [31:0] out;
        logic        eq;
        logic        lt;
        logic        ltu;
        int          cyc;
    } ExpEntry;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0Val = 1'b0, req1Val = 1'b0;
    logic        req0Rdy, req1Rdy;
    logic [3:0]  req0Fn = '0, req1Fn = '0;
    logic [31:0] req0In0 = '0, req0In1 = '0, req1In0 = '0, req1In1 = '0;
    logic        resp0Val, resp1Val;
    logic        resp0Rdy = 1'b1, resp1Rdy = 1'b1;
    logic [31:0] respOut;
    logic        respEq, respLt, respLtu;
    logic [3:0]  aluFn;
    logic [31:0] aluIn0, aluIn1, aluOut;
    logic        aluEq, aluLt, aluLtu;

    int      vectors = 0;
    int      miscompares = 0;
    int      cycleCount = 0;
    bit      checkEn = 1'b0;
    logic    modelLast = 1'b1;
    ExpEntry sb[$];

    proc_alu_share_arbiter #(.p_nbits(32)) dut (
        .clk_i(clk), .reset_i(reset),
        .req0_val_i(req0Val), .req0_rdy_o(req0Rdy), .req0_fn_i(req0Fn),
        .req0_in0_i(req0In0), .req0_in1_i(req0In1),
        .req1_val_i(req1Val), .req1_rdy_o(req1Rdy), .req1_fn_i(req1Fn),
        .req1_in0_i(req1In0), .req1_in1_i(req1In1),
        .resp0_val_o(resp0Val), .resp0_rdy_i(resp0Rdy),
        .resp1_val_o(resp1Val), .resp1_rdy_i(resp1Rdy),
        .resp_out_o(respOut), .resp_eq_o(respEq), .resp_lt_o(respLt), .resp_ltu_o(respLtu),
        .alu_fn_o(aluFn), .alu_in0_o(aluIn0), .alu_in1_o(aluIn1),
        .alu_out_i(aluOut), .alu_eq_i(aluEq), .alu_lt_i(aluLt), .alu_ltu_i(aluLtu)
    );

    // Golden proc ALU
    function automatic logic [31:0] aluRef(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (fn)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return 32'($signed(a) >>> sh);
            4'd8:  return a >> sh;
            4'd9:  return a << sh;
            4'd11: return a;
            4'd12: return b;
            default: return 32'd0;
        endcase
    endfunction

    assign aluOut = aluRef(aluFn, aluIn0, aluIn1);
    assign aluEq  = (aluIn0 == aluIn1);
    assign aluLt  = ($signed(aluIn0) < $signed(aluIn1));
    assign aluLtu = (aluIn0 < aluIn1);

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCount);
        end
    endtask

    // One cycle of stimulus; the model decides who should be granted and
    // queues the expected response for anything accepted.
    task automatic applyStimulus(
        input logic v0, input logic [3:0] f0, input logic [31:0] a0, input logic [31:0] b0,
        input logic v1, input logic [3:0] f1, input logic [31:0] a1, input logic [31:0] b1,
        input logic r0, input logic r1);
        logic    g, gv, free;
        ExpEntry e;
        @(negedge clk);
        req0Val = v0; req0Fn = f0; req0In0 = a0; req0In1 = b0;
        req1Val = v1; req1Fn = f1; req1In0 = a1; req1In1 = b1;
        resp0Rdy = r0; resp1Rdy = r1;
        #2;
        gv   = v0 | v1;
        g    = (v0 && v1) ? ~modelLast : v1;
        free = (sb.size() == 0) || (sb[0].id ? r1 : r0);
        checkOutput("req0_rdy", 32'(req0Rdy), 32'(free && gv && !g));
        checkOutput("req1_rdy", 32'(req1Rdy), 32'(free && gv && g));
        if (free && gv) begin
            e.id  = g;
            e.out = g ? aluRef(f1, a1, b1) : aluRef(f0, a0, b0);
            e.eq  = g ? (a1 == b1) : (a0 == b0);
            e.lt  = g ? ($signed(a1) < $signed(b1)) : ($signed(a0) < $signed(b0));
            e.ltu = g ? (a1 < b1) : (a0 < b0);
            e.cyc = cycleCount;
            sb.push_back(e);
            modelLast = g;
        end
    endtask

    task automatic doReset(input int n);
        @(negedge clk);
        reset = 1'b1;
        req0Val = 1'b1; req1Val = 1'b1;
        resp0Rdy = 1'b1; resp1Rdy = 1'b1;
        sb.delete();
        modelLast = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            checkOutput("reset_resp0_val", 32'(resp0Val), 32'd0);
            checkOutput("reset_resp1_val", 32'(resp1Val), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        req0Val = 1'b0; req1Val = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 1);
    endtask

    // Monitor: response valids must match the queue head's owner one cycle
    // after acceptance, data must match while presented, pop on consume.
    always begin
        @(negedge clk);
        #3;
        if (checkEn && !reset) begin
            for (int n = 0; n < 2; n++) begin
                logic expV, actV;
                expV = (sb.size() > 0) && (sb[0].cyc < cycleCount) && (sb[0].id == n[0]);
                actV = n[0] ? resp1Val : resp0Val;
                checkOutput(n[0] ? "resp1_val" : "resp0_val", 32'(actV), 32'(expV));
                if (expV && actV) begin
                    checkOutput("resp_out", respOut, sb[0].out);
                    checkOutput("resp_eq", 32'(respEq), 32'(sb[0].eq));
                    checkOutput("resp_lt", 32'(respLt), 32'(sb[0].lt));
                    checkOutput("resp_ltu", 32'(respLtu), 32'(sb[0].ltu));
                end
            end
            if ((sb.size() > 0) && (sb[0].cyc < cycleCount) && (sb[0].id ? resp1Rdy : resp0Rdy))
                void'(sb.pop_front());
        end
    end

    logic [3:0] validFns [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12};

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 8));
            1: return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // reset with both requesters valid, then first tie goes to req0
        doReset(2);
        checkEn = 1'b1;
        applyStimulus(1, 4'd0, 32'd10, 32'd20, 1, 4'd1, 32'd9, 32'd4, 1, 1);
        idle(2);

        // single ADD 5+7
        applyStimulus(1, 4'd0, 32'd5, 32'd7, 0, 4'd0, 0, 0, 1, 1);
        idle(2);

        // contention: grants must alternate
        repeat (4) applyStimulus(1, 4'd1, 32'd3, 32'd5, 1, 4'd5, 32'hFFFF_FFFF, 32'd1, 1, 1);
        idle(2);

        // back-pressure on resp0 blocks both requesters
        applyStimulus(1, 4'd4, 32'hF0, 32'hFF, 0, 4'd0, 0, 0, 0, 1);
        repeat (3) applyStimulus(1, 4'd0, 32'd1, 32'd1, 1, 4'd2, 32'd6, 32'd3, 0, 1);
        applyStimulus(0, 4'd0, 0, 0, 1, 4'd3, 32'h10, 32'h01, 1, 1);
        idle(2);

        // reset while req1's result is still in the slot
        applyStimulus(0, 4'd0, 0, 0, 1, 4'd9, 32'd1, 32'd4, 1, 0);
        doReset(1);
        idle(4);

        // randomized traffic on both sides
        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, validFns[$urandom_range(0, 11)], randOperand(), randOperand(),
                          $urandom_range(0, 3) != 0, validFns[$urandom_range(0, 11)], randOperand(), randOperand(),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        idle(6);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
